bin_to_hex_display: RTL

//  Converts an unsigned binary word to NDIG decimal digits with an iterative shift-add-3 (double dabble) engine.

---
 rtl/seg7_pkg.sv | 35 +++
 rtl/bcd_to_7seg.sv | 13 +
 rtl/bin_to_hex_display.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment constants, digit decoder function and converter FSM states.
// Latency: none (declarations only).
// Backpressure: not applicable.
package seg7_pkg;

  // Active-low segment fields, bit6=a .. bit0=g
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } cvt_state_t;

  // Decimal digit to segment pattern; non-decimal codes show nothing
  function automatic logic [6:0] seg7_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to active-low 7-segment pattern.
// Latency: 0 cycles.
// Backpressure: none, pure combinational.
module bcd_to_7seg
  import seg7_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  assign o_seg = seg7_digit(i_digit);

endmodule

// File: rtl/bin_to_hex_display.sv
// Binary to NDIG-digit decimal 7-segment driver using an iterative double-dabble engine.
// Latency: done pulses BIN_W+1 cycles after start is sampled.
// Backpressure: start is ignored while a conversion is in flight; no queueing.
module bin_to_hex_display
  import seg7_pkg::*;
#(
  parameter int BIN_W = 14,
  parameter int NDIG  = 4
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic              start,
  input  logic [BIN_W-1:0]  bin_in,
  input  logic              blank_lz,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [NDIG*7-1:0] hex_out
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = NDIG * 4;
  // Compare one bit wider than the input so the limit itself always fits
  localparam logic [BIN_W:0] OVF_LIM = (BIN_W + 1)'(10 ** NDIG);

  cvt_state_t         r_state;
  cvt_state_t         w_state_nxt;
  logic [BIN_W-1:0]   r_bin;
  logic [BCD_W-1:0]   r_bcd;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_blank;
  logic               r_ovf;
  logic               r_done;
  logic               r_overflow;
  logic [NDIG*7-1:0]  r_hex;
  logic               w_load;
  logic               w_last;
  logic [BCD_W-1:0]   w_adj;
  logic [BCD_W+BIN_W-1:0] w_shift;
  logic [NDIG-1:0]    w_mask;
  logic               w_lead;
  logic [NDIG*7-1:0]  w_seg;
  logic [NDIG*7-1:0]  w_hex_nxt;

  assign busy     = (r_state == ST_SHIFT);
  assign done     = r_done;
  assign overflow = r_overflow;
  assign hex_out  = r_hex;
  assign w_last   = (r_cnt == CNT_W'(BIN_W - 1));

  // State register
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic: IDLE accepts start, SHIFT runs BIN_W steps, DONE publishes
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: if (w_last) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Add-3 correction on every BCD digit that would overflow when doubled
  always_comb begin
    w_adj = r_bcd;
    for (int k = 0; k < NDIG; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
    end
    w_shift = {w_adj, r_bin} << 1;
  end

  // Leading-zero mask: a digit is blank while it and every digit above it are zero
  always_comb begin
    w_mask = '0;
    w_lead = 1'b1;
    for (int k = NDIG - 1; k >= 1; k--) begin
      w_lead    = w_lead && (r_bcd[4*k +: 4] == 4'd0);
      w_mask[k] = w_lead && r_blank;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NDIG; g++) begin : g_dig
      bcd_to_7seg u_seg (
        .i_digit (r_bcd[4*g +: 4]),
        .o_seg   (w_seg[7*g +: 7])
      );
    end
  endgenerate

  // Final display image: dashes on overflow, else decoded digits with blanking
  always_comb begin
    w_hex_nxt = w_seg;
    for (int k = 0; k < NDIG; k++) begin
      if (r_ovf)          w_hex_nxt[7*k +: 7] = SEG_DASH;
      else if (w_mask[k]) w_hex_nxt[7*k +: 7] = SEG_BLANK;
    end
  end

  // Conversion datapath and output registers
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_blank    <= 1'b0;
      r_ovf      <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      r_hex      <= {NDIG{SEG_BLANK}};
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_bin   <= bin_in;
        r_bcd   <= '0;
        r_cnt   <= '0;
        r_blank <= blank_lz;
        r_ovf   <= ({1'b0, bin_in} >= OVF_LIM);
      end else if (r_state == ST_SHIFT) begin
        r_bcd <= w_shift[BCD_W+BIN_W-1:BIN_W];
        r_bin <= w_shift[BIN_W-1:0];
        r_cnt <= r_cnt + 1'b1;
      end else if (r_state == ST_DONE) begin
        r_hex      <= w_hex_nxt;
        r_overflow <= r_ovf;
        r_done     <= 1'b1;
      end
    end
  end

endmodule
